instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Fetch stage of the 8-bit processor; sits directly upstream of control_unit.
//  Holds the PC, requests 8-bit instruction bytes from instruction memory over req/ack,
//  and latches each byte into an instruction register (IR).
//  Presents IR[7:5] to control_unit with a valid flag, holds it under downstream stall,
//  and halts on an undefined opcode.
// PARAMETERS
//  PC_W      8     PC / instruction-memory address width (bits)
//  RESET_PC  0     PC value loaded on reset
// PORTS
//  clk          in   1     single clock; all state updates on rising edge
//  reset_n      in   1     synchronous reset, active-low
//  imem_req     out  1     fetch request to instruction memory
//  imem_addr    out  PC_W  fetch address (= PC)
//  imem_rdata   in   8     instruction byte; valid when imem_ack=1
//  imem_ack     in   1     memory accepts the request and returns rdata this cycle
//  stall        in   1     downstream cannot accept; hold current instruction
//  instr        out  8     IR contents; [7:5] feed control_unit InputBits
//  instr_valid  out  1     instr holds a legal, un-consumed instruction
//  pc_out       out  PC_W  address the current instr was fetched from
//  halted       out  1     stage halted; sticky until reset
//  illegal_op   out  1     halt was caused by an undefined opcode; sticky
// BEHAVIOUR
//  - Reset (reset_n=0 at edge): state=IDLE, PC=RESET_PC, instr=8'h00; all outputs 0
//    except imem_addr/pc_out=RESET_PC. Reset wins over every other event in that cycle.
//  - FSM states and transitions:
//    IDLE  -> FETCH unconditionally; provides one quiet cycle after reset release.
//    FETCH -> imem_req=1, imem_addr=PC, both held stable until imem_ack.
//             On ack with a legal opcode: IR<=imem_rdata, go to ISSUE.
//             On ack with an illegal opcode: go to HALT; IR is not loaded.
//    ISSUE -> instr_valid=1.
//             stall=1: hold IR, PC and valid.
//             stall=0: PC<=PC+1, go to FETCH (instr_valid drops next cycle).
//    HALT  -> req=0, valid=0, halted=1. Exits only via reset.
//  - Legal opcodes (IR[7:5]) are 000 add, 100 addi, 101 sw, 110 lw, 111 sll.
//    Opcodes 001/010/011 are illegal and set illegal_op=1 together with halted=1.
//  - Latency: ack in cycle N -> instr_valid=1 in N+1. Zero-wait memory gives
//    1 instruction per 2 cycles.
//  - PC increments modulo 2^PC_W; 0xFF wraps to 0x00 with no flag.
//  - imem_ack outside FETCH is ignored, and imem_rdata is ignored without ack.
//  - stall outside ISSUE has no effect. A stall asserted in the ack cycle does not block the IR load.
//  - All outputs are registered or decoded from state only; no combinational path
//    from stall/ack to imem_req.
// STRUCTURE
//  - cpu_pkg: OP_ADD=3'b000, OP_ADDI=3'b100, OP_SW=3'b101, OP_LW=3'b110, OP_SLL=3'b111;
//    function op_is_legal(); typedef enum fetch_state_t {IDLE,FETCH,ISSUE,HALT}.
//    control_unit migrates to these constants.
//  - Sub-module pc_reg (PC_W, RESET_PC): load/increment/hold register with wrap.
//    FSM and IR live in instr_fetch.
// TESTING
//  1 reset_n=0 for 3 cycles, then 1 -> req=0 in the IDLE cycle; req=1 with addr=0x00
//    on the next cycle; valid/halted/illegal_op=0 throughout.
//  2 zero-wait memory returning 0x00, 0x84, 0xA3 -> instr_valid pulses 1 cycle each,
//    2 cycles apart; pc_out=0,1,2; instr matches each byte.
//  3 ack delayed 3 cycles at addr 0x05 -> req and addr=0x05 held stable all 3 cycles;
//    instr_valid rises the cycle after ack.
//  4 stall=1 for 4 cycles during ISSUE of 0xC1 -> instr=0xC1, valid=1, pc_out constant;
//    next fetch at PC+1 only after stall drops.
//  5 PC=0xFF fetch of 0xE0, then stall=0 -> next imem_addr=0x00.
//  6 fetch returns 0x40 (opcode 010) -> halted=1 and illegal_op=1, valid never rises,
//    req stays 0 after; reset_n=0 for 1 cycle restores state IDLE and PC=0.
//    Also: reset asserted mid-FETCH while ack=1 -> IR not loaded.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit processor front end.
// Holds the opcode constants (IR[7:5]), the legality check and the fetch FSM state type.
// control_unit decodes against the same constants.
package cpu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b100;
  localparam logic [2:0] OP_SW   = 3'b101;
  localparam logic [2:0] OP_LW   = 3'b110;
  localparam logic [2:0] OP_SLL  = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  // Opcodes 001/010/011 are undefined and halt the fetch stage.
  function automatic logic op_is_legal(input logic [2:0] op);
    logic legal;
    legal = 1'b0;
    unique case (op)
      OP_ADD, OP_ADDI, OP_SW, OP_LW, OP_SLL: legal = 1'b1;
      default:                               legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/acknowledge bus.
//   req   : fetch request (master -> slave)
//   addr  : fetch address, PC_W bits (master -> slave)
//   rdata : instruction byte, valid while ack=1 (slave -> master)
//   ack   : request accepted, rdata returned this cycle (slave -> master)
interface instr_fetch_if #(
  parameter int unsigned PC_W = 8
);

  logic            req;
  logic [PC_W-1:0] addr;
  logic [7:0]      rdata;
  logic            ack;

  modport master (
    output req,
    output addr,
    input  rdata,
    input  ack
  );

  modport slave (
    input  req,
    input  addr,
    output rdata,
    output ack
  );

endinterface

// File: rtl/instr_fetch_pc_reg.sv
// Program counter register: load, increment (modulo 2^PC_W) or hold.
//   clk      : clock
//   reset_n  : synchronous active-low reset, loads RESET_PC
//   load     : load load_val (takes priority over inc)
//   load_val : value to load
//   inc      : advance PC by one, wrapping silently
//   pc       : current PC
module pc_reg #(
  parameter int unsigned     PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load,
  input  logic [PC_W-1:0] load_val,
  input  logic            inc,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_val;
    end else if (inc) begin
      pc_d = pc_q + PC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage of the 8-bit processor, upstream of control_unit.
// Requests instruction bytes at PC, latches them into the IR, presents the IR with a valid
// flag until downstream accepts it, and halts permanently (until reset) on an undefined opcode.
//   clk         : clock, rising edge
//   reset_n     : synchronous active-low reset
//   imem        : instruction-memory bus (master side)
//   stall       : downstream cannot accept; hold current instruction
//   instr       : IR contents, [7:5] feed control_unit
//   instr_valid : instr holds a legal, un-consumed instruction
//   pc_out      : address instr was fetched from
//   halted      : stage halted, sticky until reset
//   illegal_op  : halt caused by an undefined opcode, sticky
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned     PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  instr_fetch_if.master        imem,
  input  logic                 stall,
  output logic [7:0]           instr,
  output logic                 instr_valid,
  output logic [PC_W-1:0]      pc_out,
  output logic                 halted,
  output logic                 illegal_op
);

  fetch_state_t    state_q;
  logic [7:0]      ir_q;
  logic            illegal_q;
  logic [PC_W-1:0] pc;
  logic            pc_inc;

  // PC only moves when an issued instruction is consumed, so it always names the IR's source.
  assign pc_inc = (state_q == ISSUE) && !stall;

  pc_reg #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (1'b0),
    .load_val (RESET_PC),
    .inc      (pc_inc),
    .pc       (pc)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ir_q      <= 8'h00;
      illegal_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_q <= FETCH;
        end
        FETCH: begin
          if (imem.ack) begin
            if (op_is_legal(imem.rdata[7:5])) begin
              ir_q    <= imem.rdata;
              state_q <= ISSUE;
            end else begin
              illegal_q <= 1'b1;
              state_q   <= HALT;
            end
          end
        end
        ISSUE: begin
          if (!stall) begin
            state_q <= FETCH;
          end
        end
        HALT: begin
          state_q <= HALT;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Outputs depend on registered state only; no path from stall/ack to req.
  assign imem.req    = (state_q == FETCH);
  assign imem.addr   = pc;
  assign instr       = ir_q;
  assign instr_valid = (state_q == ISSUE);
  assign pc_out      = pc;
  assign halted      = (state_q == HALT);
  assign illegal_op  = illegal_q;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
  import cpu_pkg::*;

  logic       clk;
  logic       reset_n;
  logic       stall;
  logic [7:0] instr;
  logic       instr_valid;
  logic [7:0] pc_out;
  logic       halted;
  logic       illegal_op;

  int total;
  int bad;

  instr_fetch_if #(.PC_W(8)) bus ();

  instr_fetch #(
    .PC_W     (8),
    .RESET_PC (8'h00)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .imem        (bus),
    .stall       (stall),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc_out      (pc_out),
    .halted      (halted),
    .illegal_op  (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From a FETCH cycle: zero-wait ack of a legal byte, then consume it without stall.
  task automatic fetch_one(input logic [7:0] b);
    bus.ack   = 1'b1;
    bus.rdata = b;
    tick();
    bus.ack   = 1'b0;
    bus.rdata = 8'h00;
    stall     = 1'b0;
    tick();
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset_n   = 1'b0;
    stall     = 1'b0;
    bus.ack   = 1'b0;
    bus.rdata = 8'h00;

    // 1: reset, IDLE quiet cycle, then first request at 0x00
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_req", bus.req, 0);
      chk("rst_valid", instr_valid, 0);
    end
    chk("rst_addr", bus.addr, 8'h00);
    chk("rst_instr", instr, 8'h00);
    chk("rst_halted", halted, 0);
    chk("rst_illegal", illegal_op, 0);
    reset_n = 1'b1;
    #1;
    chk("idle_req", bus.req, 0);
    tick();
    chk("fetch0_req", bus.req, 1);
    chk("fetch0_addr", bus.addr, 8'h00);
    chk("fetch0_valid", instr_valid, 0);

    // 2: zero-wait stream 0x00, 0x84, 0xA3
    bus.ack = 1'b1; bus.rdata = 8'h00;
    tick();
    bus.ack = 1'b0;
    chk("s0_valid", instr_valid, 1);
    chk("s0_instr", instr, 8'h00);
    chk("s0_pc", pc_out, 8'h00);
    chk("s0_req", bus.req, 0);
    tick();
    chk("s0_drop", instr_valid, 0);
    chk("s1_addr", bus.addr, 8'h01);
    bus.ack = 1'b1; bus.rdata = 8'h84;
    tick();
    bus.ack = 1'b0;
    chk("s1_valid", instr_valid, 1);
    chk("s1_instr", instr, 8'h84);
    chk("s1_pc", pc_out, 8'h01);
    tick();
    chk("s1_drop", instr_valid, 0);
    bus.ack = 1'b1; bus.rdata = 8'hA3;
    tick();
    bus.ack = 1'b0;
    chk("s2_instr", instr, 8'hA3);
    chk("s2_pc", pc_out, 8'h02);
    tick();

    // 3: advance to 0x05, then ack delayed 3 cycles
    fetch_one(8'h00);
    fetch_one(8'h00);
    for (int i = 0; i < 3; i++) begin
      chk("wait_req", bus.req, 1);
      chk("wait_addr", bus.addr, 8'h05);
      chk("wait_valid", instr_valid, 0);
      bus.rdata = 8'hFF;
      tick();
    end
    bus.ack = 1'b1; bus.rdata = 8'h00;
    tick();
    chk("late_valid", instr_valid, 1);
    chk("late_pc", pc_out, 8'h05);
    // ack in ISSUE is ignored even with an illegal byte
    bus.rdata = 8'h40; stall = 1'b1;
    tick();
    chk("ack_issue_instr", instr, 8'h00);
    chk("ack_issue_halt", halted, 0);
    chk("ack_issue_valid", instr_valid, 1);
    bus.ack = 1'b0; stall = 1'b0;
    tick();
    chk("f6_addr", bus.addr, 8'h06);

    // 4: stall in ack cycle does not block load; stall 4 cycles
    bus.ack = 1'b1; bus.rdata = 8'hC1; stall = 1'b1;
    tick();
    bus.ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("stall_instr", instr, 8'hC1);
      chk("stall_valid", instr_valid, 1);
      chk("stall_pc", pc_out, 8'h06);
      chk("stall_req", bus.req, 0);
      if (i < 3) tick();
    end
    stall = 1'b0;
    tick();
    chk("post_stall_addr", bus.addr, 8'h07);
    chk("post_stall_req", bus.req, 1);

    // 5: run up to 0xFF, fetch 0xE0, wrap to 0x00
    for (int a = 7; a < 255; a++) fetch_one(8'h00);
    chk("ff_addr", bus.addr, 8'hFF);
    bus.ack = 1'b1; bus.rdata = 8'hE0;
    tick();
    bus.ack = 1'b0;
    chk("ff_instr", instr, 8'hE0);
    chk("ff_pc", pc_out, 8'hFF);
    tick();
    chk("wrap_addr", bus.addr, 8'h00);
    chk("wrap_req", bus.req, 1);

    // 6: illegal opcode 010 halts
    bus.ack = 1'b1; bus.rdata = 8'h40;
    tick();
    bus.ack = 1'b0;
    chk("ill_halted", halted, 1);
    chk("ill_flag", illegal_op, 1);
    chk("ill_instr", instr, 8'hE0);
    for (int i = 0; i < 3; i++) begin
      chk("halt_req", bus.req, 0);
      chk("halt_valid", instr_valid, 0);
      bus.ack = 1'b1; bus.rdata = 8'h00;
      tick();
    end
    bus.ack = 1'b0;
    chk("halt_sticky", halted, 1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("rr_halted", halted, 0);
    chk("rr_illegal", illegal_op, 0);
    chk("rr_pc", pc_out, 8'h00);
    chk("rr_instr", instr, 8'h00);
    chk("rr_req", bus.req, 0);
    tick();
    chk("rr_fetch_req", bus.req, 1);
    fetch_one(8'h84);
    chk("pre_mid_addr", bus.addr, 8'h01);
    // reset in a FETCH cycle with ack: IR must not load
    reset_n = 1'b0; bus.ack = 1'b1; bus.rdata = 8'hA3;
    tick();
    bus.ack = 1'b0; reset_n = 1'b1;
    chk("mid_instr", instr, 8'h00);
    chk("mid_valid", instr_valid, 0);
    chk("mid_pc", pc_out, 8'h00);
    tick();
    chk("mid_fetch_addr", bus.addr, 8'h00);
    chk("mid_fetch_req", bus.req, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
